// File: rtl/vec_mag_apb_master.sv
// vec_mag_apb_master: turns single commands into APB3 transfers and returns one response per command.
// Optional feature: define VEC_MAG_APB_MST_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without pready_i.
// TXN_CNT_RESET is the value txn_cnt_o takes in reset; it stays 0 in normal use.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// A valid is never withdrawn before its transfer. The payload stays stable while valid waits for ready.
// cmd_*: the master offers ready only in IDLE. rsp_*: the master holds valid and its data until ready.
module vec_mag_apb_master #(
   parameter int          APB_ADDR_WIDTH = 12,
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [15:0] TXN_CNT_RESET  = 16'h0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic                      cmd_write_i,
   input  logic [31:0]               cmd_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [31:0]               pwdata_o,
   input  logic [31:0]               prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i,
   output logic [15:0]               txn_cnt_o,
   output logic [1:0]                dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic                      armed_q;
   logic [APB_ADDR_WIDTH-1:0] addr_q;
   logic                      write_q;
   logic [31:0]               wdata_q;
   logic [31:0]               rdata_q;
   logic                      err_q;
   logic [15:0]               cnt_q;
   logic                      cmd_hs;
   logic                      done;
   logic                      abort;

   // armed_q keeps cmd_ready_o low until the first edge after reset release.
   assign cmd_ready_o = armed_q && (state_q == IDLE);
   assign cmd_hs      = cmd_valid_i && cmd_ready_o;
   assign done        = (state_q == ACCESS) && pready_i;

`ifdef VEC_MAG_APB_MST_TIMEOUT_EN
   logic [15:0] acc_cnt_q;
   logic        timeout_q;

   // An abort happens only on the TIMEOUT_CYCLES-th ACCESS cycle, and only if pready_i is low then.
   assign abort = (state_q == ACCESS) && !pready_i && (acc_cnt_q == 16'(TIMEOUT_CYCLES - 1));

   // Count ACCESS cycles of the current transfer. The counter is 0 on the first ACCESS cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                acc_cnt_q <= '0;
      else if (state_q == ACCESS) acc_cnt_q <= acc_cnt_q + 16'd1;
      else                       acc_cnt_q <= '0;
   end

   // Timeout flag of the response. It changes only when ACCESS ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     timeout_q <= 1'b0;
      else if (done)  timeout_q <= 1'b0;
      else if (abort) timeout_q <= 1'b1;
   end

   assign rsp_timeout_o = timeout_q;
`else
   assign abort         = 1'b0;
   assign rsp_timeout_o = 1'b0;
`endif

   // State register and the flag that arms cmd_ready_o after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
      end
   end

   // Next-state logic and the APB strobes decoded from the state.
   always_comb begin
      state_d   = state_q;
      psel_o    = 1'b0;
      penable_o = 1'b0;
      case (state_q)
         IDLE:    if (cmd_hs) state_d = SETUP;
         SETUP: begin
            psel_o  = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel_o    = 1'b1;
            penable_o = 1'b1;
            if (done || abort) state_d = RESP;
         end
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the command on its handshake. Write data is zeroed for reads so pwdata_o stays 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else if (cmd_hs) begin
         addr_q  <= cmd_addr_i;
         write_q <= cmd_write_i;
         wdata_q <= cmd_write_i ? cmd_wdata_i : 32'h0;
      end
   end

   // Capture the response when ACCESS ends. The response then holds through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (done) begin
         rdata_q <= write_q ? 32'h0 : prdata_i;
         err_q   <= pslverr_i;
      end else if (abort) begin
         rdata_q <= '0;
         err_q   <= 1'b1;
      end
   end

   // Completed-transfer counter. Aborted transfers also count. The counter wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              cnt_q <= TXN_CNT_RESET;
      else if (done || abort)  cnt_q <= cnt_q + 16'd1;
   end

   assign paddr_o     = addr_q;
   assign pwrite_o    = write_q;
   assign pwdata_o    = wdata_q;
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign txn_cnt_o   = cnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vec_mag_apb_master.sv
// Testbench for vec_mag_apb_master.
// A transaction-level model predicts every output on every negedge.
// Directed transfers add hand-computed checks on top of the model.
// A second instance starts its counter at 0xFFFE to exercise the wrap.
module tb_vec_mag_apb_master;
   localparam int AW = 12;
   localparam int TO = 4;
`ifdef VEC_MAG_APB_MST_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid, cmd_write, rsp_ready, pready, pslverr;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata, prdata;

   logic          cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, psel_o, penable_o, pwrite_o;
   logic [31:0]   rsp_rdata_o, pwdata_o;
   logic [AW-1:0] paddr_o;
   logic [15:0]   txn_cnt_o;
   logic [1:0]    dbg_state_o;

   logic          w_cmd_ready, w_rsp_valid, w_rsp_err, w_rsp_timeout, w_psel, w_penable, w_pwrite;
   logic [31:0]   w_rsp_rdata, w_pwdata;
   logic [AW-1:0] w_paddr;
   logic [15:0]   w_txn_cnt;
   logic [1:0]    w_dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vec_mag_apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr),
      .cmd_write_i(cmd_write), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
      .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
      .pwdata_o(pwdata_o), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
      .txn_cnt_o(txn_cnt_o), .dbg_state_o(dbg_state_o));

   vec_mag_apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .TXN_CNT_RESET(16'hFFFE)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(w_cmd_ready), .cmd_addr_i(cmd_addr),
      .cmd_write_i(cmd_write), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(w_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(w_rsp_rdata),
      .rsp_err_o(w_rsp_err), .rsp_timeout_o(w_rsp_timeout),
      .psel_o(w_psel), .penable_o(w_penable), .pwrite_o(w_pwrite), .paddr_o(w_paddr),
      .pwdata_o(w_pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
      .txn_cnt_o(w_txn_cnt), .dbg_state_o(w_dbg_state));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction model ----------------
   // m_k counts cycles since the command handshake: 1 is SETUP, and k>=2 is ACCESS cycle k-1.
   logic          m_live, m_busy, m_rsp, m_write, m_err, m_to;
   int            m_k;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata, m_rdata;
   logic [15:0]   m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_live <= 1'b0; m_busy <= 1'b0; m_rsp <= 1'b0; m_k <= 0;
         m_addr <= '0; m_write <= 1'b0; m_wdata <= '0;
         m_rdata <= '0; m_err <= 1'b0; m_to <= 1'b0; m_cnt <= '0;
      end else begin
         m_live <= 1'b1;
         if (m_rsp) begin
            if (rsp_ready) m_rsp <= 1'b0;
         end else if (m_busy) begin
            if (m_k >= 2 && pready) begin
               m_busy  <= 1'b0; m_rsp <= 1'b1;
               m_rdata <= m_write ? 32'h0 : prdata;
               m_err   <= pslverr; m_to <= 1'b0;
               m_cnt   <= m_cnt + 16'd1;
            end else if (TO_EN && m_k >= 2 && (m_k - 1) == TO) begin
               m_busy  <= 1'b0; m_rsp <= 1'b1;
               m_rdata <= 32'h0; m_err <= 1'b1; m_to <= 1'b1;
               m_cnt   <= m_cnt + 16'd1;
            end else begin
               m_k <= m_k + 1;
            end
         end else if (m_live && cmd_valid) begin
            m_busy  <= 1'b1; m_k <= 1;
            m_addr  <= cmd_addr; m_write <= cmd_write;
            m_wdata <= cmd_write ? cmd_wdata : 32'h0;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      chk("cmd_ready", cmd_ready_o, m_live && !m_busy && !m_rsp);
      chk("psel", psel_o, m_busy);
      chk("penable", penable_o, m_busy && m_k >= 2);
      chk("rsp_valid", rsp_valid_o, m_rsp);
      chk("txn_cnt", txn_cnt_o, m_cnt);
      chk("wrap_txn_cnt", w_txn_cnt, 16'(m_cnt + 16'hFFFE));
      if (m_busy) begin
         chk("paddr", paddr_o, m_addr);
         chk("pwrite", pwrite_o, m_write);
         chk("pwdata", pwdata_o, m_wdata);
      end
      if (m_rsp) begin
         chk("rsp_rdata", rsp_rdata_o, m_rdata);
         chk("rsp_err", rsp_err_o, m_err);
         chk("rsp_timeout", rsp_timeout_o, m_to);
      end
   end

   // ---------------- driver tasks ----------------
   // Present a command and hold it until the handshake edge. Returns just after that edge.
   task automatic start_cmd(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata);
      logic got;
      got = 1'b0;
      cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_wdata = wdata;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_ready_o) begin got = 1'b1; break; end
      end
      chk("cmd_handshake_seen", got, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_write = 1'($urandom); cmd_wdata = $urandom;
   endtask

   // Step to the first ACCESS cycle. Returns 1 ns after the edge that entered it.
   task automatic wait_access(output int steps);
      logic got;
      got = 1'b0; steps = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1; steps++;
         if (psel_o && penable_o) begin got = 1'b1; break; end
      end
      chk("access_seen", got, 1'b1);
   endtask

   // Run one full transfer with the given wait states and response backpressure.
   // Check the response and the latency from the command handshake to rsp_valid_o.
   task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rdata, input logic slverr, input int bp);
      int lat;
      int st;
      start_cmd(addr, wr, wdata);
      lat = 1;
      wait_access(st);
      lat += st;
      for (int w = 0; w <= waits; w++) begin
         if (w < waits) begin
            pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
            @(posedge clk); #1; lat++;
         end else begin
            pready = 1'b1; prdata = rdata; pslverr = slverr;
         end
      end
      @(posedge clk); #1; lat++;
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      chk("latency", lat, 3 + waits);
      chk("rsp_valid_lit", rsp_valid_o, 1'b1);
      chk("rsp_rdata_lit", rsp_rdata_o, wr ? 32'h0 : rdata);
      chk("rsp_err_lit", rsp_err_o, slverr);
      chk("rsp_timeout_lit", rsp_timeout_o, 1'b0);
      rsp_ready = 1'b0;
      repeat (bp) begin @(posedge clk); #1; end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int st;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
      rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready_o, 1'b0);
      chk("rst_psel", psel_o, 1'b0);
      chk("rst_paddr", paddr_o, 0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
      chk("rst_txn_cnt", txn_cnt_o, 16'h0);
      chk("rst_wrap_cnt", w_txn_cnt, 16'hFFFE);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("cmd_ready_after_rst", cmd_ready_o, 1'b1);

      // Zero-wait write, then a zero-wait read that wraps the preset counter
      run_txn(12'h004, 1'b1, 32'h0000_0001, 0, 32'h0, 1'b0, 0);
      chk("cnt_after_first", txn_cnt_o, 16'd1);
      chk("wrap_cnt_ffff", w_txn_cnt, 16'hFFFF);
      run_txn(12'h010, 1'b0, 32'hFFFF_FFFF, 0, 32'h1234_5678, 1'b0, 0);
      chk("wrap_cnt_zero", w_txn_cnt, 16'h0000);

      // Read with 3 wait states, completer errors, backpressure
      run_txn(12'h0A8, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 0);
      run_txn(12'h0FC, 1'b1, 32'hA5A5_5A5A, 1, 32'h7777_7777, 1'b1, 0);
      run_txn(12'h100, 1'b0, 32'h0, 0, 32'hCAFE_F00D, 1'b1, 1);
      run_txn(12'h200, 1'b1, 32'h0BAD_CAFE, 2, 32'h0, 1'b0, 5);

      // Mixed transfers
      for (int i = 0; i < 6; i++)
         run_txn(AW'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                 $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      chk("cnt_after_12", txn_cnt_o, 16'd12);

      // Completer never ready
      start_cmd(12'h3F0, 1'b0, 32'h0);
      wait_access(st);
      pready = 1'b0;
`ifdef VEC_MAG_APB_MST_TIMEOUT_EN
      repeat (TO - 1) begin @(posedge clk); #1; end
      chk("to_still_access", psel_o && penable_o, 1'b1);
      chk("to_no_rsp_yet", rsp_valid_o, 1'b0);
      @(posedge clk); #1;
      chk("to_rsp_valid", rsp_valid_o, 1'b1);
      chk("to_rsp_err", rsp_err_o, 1'b1);
      chk("to_rsp_timeout", rsp_timeout_o, 1'b1);
      chk("to_rsp_rdata", rsp_rdata_o, 32'h0);
      chk("to_psel_off", psel_o, 1'b0);
      chk("to_penable_off", penable_o, 1'b0);
`else
      repeat (10) begin @(posedge clk); #1; end
      chk("stall_still_access", psel_o && penable_o, 1'b1);
      chk("stall_no_rsp", rsp_valid_o, 1'b0);
      pready = 1'b1; prdata = 32'h0000_0055;
      @(posedge clk); #1;
      pready = 1'b0;
      chk("stall_rsp_valid", rsp_valid_o, 1'b1);
      chk("stall_rsp_timeout", rsp_timeout_o, 1'b0);
`endif
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("cnt_after_13", txn_cnt_o, 16'd13);

      // Reset in the middle of ACCESS
      start_cmd(12'h444, 1'b1, 32'h1111_2222);
      wait_access(st);
      pready = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_psel", psel_o, 1'b0);
      chk("midrst_penable", penable_o, 1'b0);
      chk("midrst_cmd_ready", cmd_ready_o, 1'b0);
      chk("midrst_txn_cnt", txn_cnt_o, 16'h0);
      chk("midrst_pwdata", pwdata_o, 32'h0);
      pready = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      pready = 1'b0;
      @(posedge clk); #1;
      chk("postrst_no_rsp", rsp_valid_o, 1'b0);
      chk("postrst_ready", cmd_ready_o, 1'b1);
      run_txn(12'h008, 1'b0, 32'h0, 1, 32'h0BEE_F00D, 1'b0, 0);
      chk("postrst_cnt", txn_cnt_o, 16'd1);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog against a hung handshake.
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish by 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vec_mag_apb_master.md
VEC_MAG_APB_MASTER -- requirements
Module: vec_mag_apb_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12: width of the APB address.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles before abort; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid_i, input, 1 bit: command request.
REQ-006 SHALL have port cmd_ready_o, output, 1 bit: command accepted when it is high together with cmd_valid_i.
REQ-007 SHALL have ports cmd_addr_i (input, APB_ADDR_WIDTH), cmd_write_i (input, 1) and cmd_wdata_i (input, 32): command address, direction and write data.
REQ-008 SHALL have port rsp_valid_o, output, 1 bit: response available.
REQ-009 SHALL have port rsp_ready_i, input, 1 bit: response consumed when it is high together with rsp_valid_o.
REQ-010 SHALL have ports rsp_rdata_o (output, 32), rsp_err_o (output, 1) and rsp_timeout_o (output, 1): read data, error flag and timeout flag.
REQ-011 SHALL have ports psel_o, penable_o, pwrite_o (output, 1 each), paddr_o (output, APB_ADDR_WIDTH) and pwdata_o (output, 32): APB requester outputs.
REQ-012 SHALL have ports prdata_i (input, 32), pready_i (input, 1) and pslverr_i (input, 1): APB completer responses.
REQ-013 SHALL have port txn_cnt_o, output, 16 bits: count of completed transactions.

Function
REQ-014 SHALL implement a state machine with states IDLE, SETUP, ACCESS and RESP.
REQ-015 SHALL drive cmd_ready_o=1 only in IDLE.
REQ-016 SHALL, on a command handshake, register addr/write/wdata and move to SETUP on the next edge; command inputs are ignored outside IDLE.
REQ-017 SHALL, in SETUP, drive psel_o=1 and penable_o=0 with paddr_o/pwrite_o/pwdata_o equal to the registered command, then move to ACCESS unconditionally.
REQ-018 SHALL, in ACCESS, drive psel_o=1 and penable_o=1 and hold all APB outputs stable until pready_i=1.
REQ-019 SHALL, on the ACCESS cycle with pready_i=1, capture rsp_rdata_o=prdata_i (reads) or 0 (writes) and rsp_err_o=pslverr_i, increment txn_cnt_o, and move to RESP.
REQ-020 SHALL drive psel_o=0 and penable_o=0 in IDLE and RESP.
REQ-021 SHALL hold rsp_valid_o=1 with stable response fields in RESP until rsp_ready_i=1, then return to IDLE; the next command is accepted no earlier than the following cycle.
REQ-022 SHALL give a zero-wait-state transaction the cycle sequence handshake (cycle 0), SETUP (1), ACCESS (2), rsp_valid_o=1 (3).
REQ-023 SHALL wrap txn_cnt_o from 0xFFFF to 0x0000; timed-out transactions also count.
REQ-024 SHALL hold pwdata_o at 0 for read transactions.

Reset
REQ-025 SHALL, while rst_n=0, immediately force IDLE, and force psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o and rsp_timeout_o to 0, paddr_o, pwdata_o and rsp_rdata_o to 0, txn_cnt_o to 0, and cmd_ready_o to 0.
REQ-026 SHALL drive cmd_ready_o=1 from the first clock edge after rst_n deasserts.
REQ-027 SHALL, on reset mid-transaction, abandon the transaction with no response produced.

Configuration
REQ-028 SHALL, with macro VEC_MAG_APB_MST_TIMEOUT_EN defined, count ACCESS cycles and, if pready_i is still 0 on the TIMEOUT_CYCLES-th ACCESS cycle, abort to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0 and psel_o/penable_o deasserted on the next cycle.
REQ-029 SHALL give pready_i precedence over timeout when both occur on the same cycle.
REQ-030 SHALL, without the macro, wait in ACCESS indefinitely, tie rsp_timeout_o to 0, and contain no timeout counter.

Verification
REQ-031 SHALL cover a zero-wait write: addr 0x004, wdata 0x1 -> SETUP then ACCESS with pwrite_o=1, rsp_valid_o in cycle 3, rsp_err_o=0, txn_cnt_o=1.
REQ-032 SHALL cover a read with 3 wait states: prdata_i=0xDEADBEEF -> APB outputs stable for 4 ACCESS cycles, rsp_rdata_o=0xDEADBEEF.
REQ-033 SHALL cover a completer error: pslverr_i=1 with pready_i=1 -> rsp_err_o=1, rsp_timeout_o=0.
REQ-034 SHALL cover backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and its data stable, cmd_ready_o=0 throughout.
REQ-035 SHALL cover timeout (macro on, TIMEOUT_CYCLES=4): pready_i held 0 -> abort after 4 ACCESS cycles with rsp_err_o=1 and rsp_timeout_o=1; macro off -> no response.
REQ-036 SHALL cover reset and wrap: rst_n low during ACCESS -> psel_o=0 immediately; txn_cnt_o preset near 0xFFFF plus 2 transactions -> wraps to 0x0000.
